// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder.
//
// Contents:
//   state_t     - controller states (IDLE, RUN, DONE)
//   SLICE_W     - width of the shared lookahead slice (4 bits)
//   num_slices  - number of slices needed for a given operand width
//   idx_width   - width of the slice index counter (clog2 of the slice
//                 count, never less than 1)
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int num_slices(input int width);
        return width / SLICE_W;
    endfunction

    function automatic int idx_width(input int width);
        int n;
        n = width / SLICE_W;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla4_cin.sv
// Combinational 4-bit carry-lookahead slice with carry-in.
//
// Ports:
//   a, b  [3:0] in  - slice operands
//   cin         in  - carry into bit 0
//   sum   [3:0] out - slice sum
//   cout        out - carry out of bit 3
//
// Every internal carry is written in fully expanded lookahead form, so no
// carry depends on another computed carry.
module cla4_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pg
            assign p[gi] = a[gi] ^ b[gi];
            assign g[gi] = a[gi] & b[gi];
        end
    endgenerate

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle wide adder built around a single shared 4-bit carry-lookahead
// slice. Operands are accepted on a valid/ready handshake, one nibble is
// added per clock (least significant slice first) with the inter-slice
// carry held in a register, and the result is offered on a second
// valid/ready handshake.
//
// Parameters:
//   WIDTH - operand/result width; multiple of 4, at least 8
//
// Ports:
//   clk        in  - rising-edge clock
//   rst        in  - synchronous reset, active-high
//   in_valid   in  - operand pair valid
//   in_ready   out - block can accept operands (IDLE only)
//   op_a       in  - addend A
//   op_b       in  - addend B
//   cin        in  - carry into slice 0
//   sub        in  - (only with CLA_SEQ_SUB_EN) subtract op_b from op_a
//   out_valid  out - result valid (DONE only)
//   out_ready  in  - consumer accepts result
//   sum        out - registered result, modulo 2^WIDTH
//   cout       out - carry out of the top slice (for subtract: 1 = no borrow)
//
// Configuration macro:
//   CLA_SEQ_SUB_EN - adds the sub port and subtract mode.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = num_slices(WIDTH);
    localparam int IDX_W = idx_width(WIDTH);

    generate
        if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   sum_next;
    logic               cout_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;

    // Operand B and initial carry as they are latched on the accepting edge.
    // Subtraction is a + ~b + 1, so it reuses the adder datapath unchanged.
    logic [WIDTH-1:0]   b_in;
    logic               c_in;

`ifdef CLA_SEQ_SUB_EN
    assign b_in = sub ? ~op_b : op_b;
    assign c_in = sub ? 1'b1  : cin;
`else
    assign b_in = op_b;
    assign c_in = cin;
`endif

    // Split the operand registers into slices so the shared CLA can be fed
    // by a plain index mux.
    logic [SLICE_W-1:0] a_slices [N];
    logic [SLICE_W-1:0] b_slices [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slices
            assign a_slices[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_slices[gi] = b_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign slice_a = a_slices[idx_reg];
    assign slice_b = b_slices[idx_reg];

    cla4_cin u_cla4 (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Result with the current slice written in place; committed only in RUN.
    always_comb begin
        sum_next = sum_reg;
        for (int i = 0; i < N; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                sum_next[i*SLICE_W +: SLICE_W] = slice_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        a_reg        <= op_a;
                        b_reg        <= b_in;
                        carry_reg    <= c_in;
                        idx_reg      <= '0;
                        sum_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= slice_cout;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == IDX_W'(N - 1)) begin
                        cout_reg      <= slice_cout;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // sum/cout are left untouched here and after leaving,
                    // until the next accept clears sum.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Testbench for cla_seq_adder (WIDTH=16): directed cases plus random
// operand pairs checked against an arithmetic reference model.
module tb_cla_seq_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit arithmetic; subtract is a + ~b + 1.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic c, input logic s);
        logic [WIDTH-1:0] be;
        logic             ce;
        be = s ? ~b : b;
        ce = s ? 1'b1 : c;
        return {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; called 1ns after an edge with the DUT in IDLE.
    task automatic do_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s, input int bp);
        logic [WIDTH:0] exp;
        int lat;
        exp = model(a, b, c, s);
        chk("in_ready_idle", in_ready, 1);
        op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
        step();                                   // accepting edge
        in_valid = 1'b0;
        op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); cin = ~c;
        chk("in_ready_run", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", lat, 4);
        chk("sum", sum, exp[WIDTH-1:0]);
        chk("cout", cout, exp[WIDTH]);
        chk("in_ready_done", in_ready, 0);
        // Backpressure with a fresh request pending: nothing may move.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < bp; i++) begin
            op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
            step();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", sum, exp[WIDTH-1:0]);
            chk("bp_cout", cout, exp[WIDTH]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();                                   // output handshake
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_sum_hold", sum, exp[WIDTH-1:0]);
        $display("txn a=%04h b=%04h cin=%0d sub=%0d bp=%0d -> sum=%04h cout=%0d lat=%0d",
                 a, b, c, s, bp, sum, cout, lat);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        sub = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);

        // Idle without in_valid holds.
        step();
        chk("idle_hold", in_ready, 1);

        do_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        chk("dir_ffff_sum", sum, 16'h0000);
        chk("dir_ffff_cout", cout, 1);

        // Reset in the middle of RUN (after 2 slices, cout still 1 from above).
        op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("midrun_partial_sum", sum, 16'h0033);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        $display("txn mid-run reset -> sum=%04h cout=%0d", sum, cout);
        do_txn(16'h0003, 16'h0004, 1'b0, 1'b0, 0);
        chk("dir_0007", sum, 16'h0007);

        do_txn(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        chk("dir_5555", sum, 16'h5555);
        do_txn(16'h00FF, 16'h0000, 1'b1, 1'b0, 5);
        chk("dir_0100", sum, 16'h0100);

`ifdef CLA_SEQ_SUB_EN
        do_txn(16'h0005, 16'h0007, 1'b0, 1'b1, 1);
        chk("sub_fffe", sum, 16'hFFFE);
        chk("sub_borrow", cout, 0);
        do_txn(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
        chk("sub_0002", sum, 16'h0002);
        chk("sub_noborrow", cout, 1);
`endif

        for (int k = 0; k < 20; k++) begin
`ifdef CLA_SEQ_SUB_EN
            do_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
`else
            do_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0,
                   int'($urandom_range(0, 3)));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle wide adder sequencer built around one shared 4-bit carry-lookahead slice.
- Accepts WIDTH-bit operand pairs on a valid/ready handshake and adds one nibble per clock, LSB slice first.
- Carries between slices through a registered carry bit; returns the result on a second valid/ready handshake.
- Sits between operand producers and consumers wherever wide adds are needed but area for a full-width CLA is not.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- op_a  input  WIDTH  addend A
- op_b  input  WIDTH  addend B
- cin  input  1  carry-in for slice 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  carry out of the top slice

Behaviour:
- One clock; reset is synchronous and active-high.
- N = WIDTH/4 slices; slice index counter is clog2(N) bits wide, minimum 1.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE, on in_valid && in_ready at an edge:
  - latch op_a, op_b into operand registers;
  - carry register <= cin, idx <= 0;
  - clear sum to 0; go to RUN.
- IDLE without in_valid: hold state.
- RUN, each edge:
  - slice result = A[idx] + B[idx] + carry (4-bit CLA with carry-in);
  - write sum[4*idx+3:4*idx]; carry <= slice carry-out; idx <= idx+1.
  - When idx == N-1: cout <= slice carry-out, go to DONE.
- Latency: out_valid rises exactly N edges after the accepting edge (4 edges for WIDTH=16).
- DONE:
  - sum and cout held stable while out_ready=0 (unbounded backpressure).
  - On out_valid && out_ready at an edge: go to IDLE.
  - sum/cout retain their values after leaving DONE until the next accept clears sum.
- No back-to-back overlap: a new accept is possible at the earliest one edge after the output handshake.
- in_valid while not in IDLE is ignored. Operand inputs are sampled only on the accepting edge; later changes have no effect.
- Arithmetic is modulo 2^WIDTH; the carry out of the top slice appears only on cout; there is no overflow flag.
- Reset (any state, including mid-RUN): next state IDLE.
  - Reset values: sum=0, cout=0, carry=0, idx=0, operand regs=0, in_ready=1, out_valid=0.
  - Any in-flight operation is discarded.
- rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on the accepting edge.
  - When sub=1: B is latched as ~op_b and the initial carry is forced to 1, ignoring cin; result is op_a - op_b modulo 2^WIDTH.
  - cout=1 means no borrow.
  - When sub=0: behaviour is identical to the base block.
- Not defined: no sub port; the block is add-only. Logic is otherwise unchanged.

Decomposition:
- Package cla_pkg:
  - state enum {IDLE, RUN, DONE};
  - constant SLICE_W=4;
  - helper function computing N and the index width from WIDTH.
- Sub-module cla4_cin: combinational 4-bit carry-lookahead slice with carry-in.
  - Propagate/generate per bit; carries c1..c4 expanded in lookahead form.
  - Outputs 4-bit sum and carry-out.
- One instance of cla4_cin is muxed over slices by idx.

Test Plan (WIDTH=16):
- Accept 0xFFFF + 0x0001, cin=0 -> out_valid 4 edges later; sum=0x0000, cout=1.
- Accept 0x1234 + 0x4321, cin=0 -> sum=0x5555, cout=0. Confirm in_ready=0 during RUN/DONE and in_ready=1 one cycle after the output handshake.
- Accept 0x00FF + 0x0000, cin=1 -> sum=0x0100, cout=0 (carry ripples through slices 0 and 1).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and changed operands -> sum, cout and out_valid stable; no new accept; result handshakes when out_ready=1.
- Reset mid-RUN: assert rst after 2 slices -> next edge state IDLE, sum=0, cout=0, out_valid=0, in_ready=1. A following 0x0003+0x0004 gives 0x0007.
- With CLA_SEQ_SUB_EN: 0x0005 - 0x0007 with sub=1 -> sum=0xFFFE, cout=0. 0x0007 - 0x0005 -> sum=0x0002, cout=1.
